// File: rtl/fft_bf_sequencer.sv
// fft_bf_sequencer: in-place radix-2 DIT FFT sequencer.
// Walks stage/pair counters, feeds the butterfly, writes results back to RAM.
module fft_bf_sequencer #(
    parameter int N    = 2048,
    parameter int LOGN = 11,
    parameter int DW   = 41,
    parameter int AW   = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_rd_en,
    input  logic signed [DW-1:0] mem_rdata_r,
    input  logic signed [DW-1:0] mem_rdata_i,
    output logic                 mem_wr_en,
    output logic signed [DW-1:0] mem_wdata_r,
    output logic signed [DW-1:0] mem_wdata_i,
    output logic [AW-2:0]        tw_addr,
    output logic [4:0]           bf_state,
    input  logic [3:0]           bf_k,
    output logic signed [DW-1:0] bf_in_r,
    output logic signed [DW-1:0] bf_in_i,
    input  logic signed [DW-1:0] bf_out_r,
    input  logic signed [DW-1:0] bf_out_i
);
    localparam int SW = $clog2(LOGN + 1);
    localparam int PW = AW - 1;
    localparam logic [PW-1:0] P_LAST = PW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

    typedef enum logic [3:0] {
        IDLE, RDA, LDA, RDB, LDB, WRA, WRB, NEXT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q;
    logic [SW-1:0] s_q;
    logic          rd_q;
    logic [AW-1:0] p_ext, half, lo, addr_a, addr_b;
    logic          last;

    // Operand addresses and twiddle index of the current pair
    always_comb begin
        p_ext   = {1'b0, p_q};
        half    = AW'(1) << s_q;
        lo      = p_ext & (half - AW'(1));
        addr_a  = ((p_ext - lo) << 1) | lo;
        addr_b  = addr_a | half;
        tw_addr = PW'(lo << (S_LAST - s_q));
        last    = (s_q == S_LAST) && (p_q == P_LAST);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Stage/pair counters and busy flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q  <= '0;
            s_q  <= '0;
            busy <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                p_q  <= '0;
                s_q  <= '0;
                busy <= 1'b1;
            end
            if (state_q == DONE) busy <= 1'b0;
            if (state_q == NEXT) begin
                if (p_q == P_LAST) begin
                    p_q <= '0;
                    s_q <= last ? '0 : s_q + SW'(1);
                end else begin
                    p_q <= p_q + PW'(1);
                end
            end
        end
    end

    // Operand register: captures RAM data the cycle after each read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q    <= 1'b0;
            bf_in_r <= '0;
            bf_in_i <= '0;
        end else begin
            rd_q <= mem_rd_en;
            if ((state_q == LDA || state_q == LDB) && rd_q) begin
                bf_in_r <= mem_rdata_r;
                bf_in_i <= mem_rdata_i;
            end
        end
    end

    // Next state and strobes; writes wait for the butterfly phase
    always_comb begin
        state_d     = state_q;
        done        = 1'b0;
        mem_addr    = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wdata_r = '0;
        mem_wdata_i = '0;
        bf_state    = 5'd0;
        unique case (state_q)
            IDLE: if (start) state_d = RDA;
            RDA: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_a;
                state_d   = LDA;
            end
            LDA: begin
                bf_state = 5'd13;
                if (bf_k == 4'd2) state_d = RDB;
            end
            RDB: begin
                mem_rd_en = 1'b1;
                mem_addr  = addr_b;
                state_d   = LDB;
            end
            LDB: begin
                bf_state = 5'd15;
                if (bf_k == 4'd8) state_d = WRA;
            end
            WRA: begin
                bf_state = 5'd16;
                if (bf_k == 4'd9) begin
                    mem_wr_en   = 1'b1;
                    mem_addr    = addr_a;
                    mem_wdata_r = bf_out_r;
                    mem_wdata_i = bf_out_i;
                    state_d     = WRB;
                end
            end
            WRB: begin
                bf_state = 5'd17;
                if (bf_k == 4'd0) begin
                    mem_wr_en   = 1'b1;
                    mem_addr    = addr_b;
                    mem_wdata_r = bf_out_r;
                    mem_wdata_i = bf_out_i;
                    state_d     = NEXT;
                end
            end
            NEXT: state_d = last ? DONE : RDA;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fft_bf_sequencer.sv
// tb_fft_bf_sequencer: N=8 FFT run against RAM, ROM and butterfly models.
// Expected traffic comes from a pair-by-pair reference FFT.
module tb_fft_bf_sequencer;
    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int DW   = 41;
    localparam int AW   = 3;
    localparam int NB   = LOGN * N / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [AW-2:0] tw_addr;
    logic [4:0] bf_state;
    logic [3:0] bf_k;
    logic signed [DW-1:0] mem_rdata_r, mem_rdata_i;
    logic signed [DW-1:0] mem_wdata_r, mem_wdata_i;
    logic signed [DW-1:0] bf_in_r, bf_in_i, bf_out_r, bf_out_i;

    always #5 clk = ~clk;

    fft_bf_sequencer #(.N(N), .LOGN(LOGN), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata_r(mem_rdata_r), .mem_rdata_i(mem_rdata_i),
        .mem_wr_en(mem_wr_en),
        .mem_wdata_r(mem_wdata_r), .mem_wdata_i(mem_wdata_i),
        .tw_addr(tw_addr), .bf_state(bf_state), .bf_k(bf_k),
        .bf_in_r(bf_in_r), .bf_in_i(bf_in_i),
        .bf_out_r(bf_out_r), .bf_out_i(bf_out_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic longint twr(input int t);
        case (t)
            0: return 127;
            1: return 90;
            2: return 0;
            default: return -90;
        endcase
    endfunction

    function automatic longint twi(input int t);
        case (t)
            0: return 0;
            1: return -90;
            2: return -127;
            default: return -90;
        endcase
    endfunction

    // Data RAM with one-cycle read latency, plus a bulk preload port
    logic signed [DW-1:0] ram_r [N];
    logic signed [DW-1:0] ram_i [N];
    longint init_r [N];
    longint init_i [N];
    logic do_init = 1'b0;

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < N; i++) begin
                ram_r[i] <= init_r[i][DW-1:0];
                ram_i[i] <= init_i[i][DW-1:0];
            end
        end else if (mem_wr_en) begin
            ram_r[mem_addr] <= mem_wdata_r;
            ram_i[mem_addr] <= mem_wdata_i;
        end
        if (mem_rd_en) begin
            mem_rdata_r <= ram_r[mem_addr];
            mem_rdata_i <= ram_i[mem_addr];
        end
    end

    // Butterfly model: phase counter runs once kicked by state 13, may stall
    logic [3:0] k;
    logic stall = 1'b0;
    longint ca_r, ca_i, cb_r, cb_i, cw_r, cw_i;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= 4'd0;
            ca_r <= 0; ca_i <= 0; cb_r <= 0; cb_i <= 0;
            cw_r <= 0; cw_i <= 0;
        end else begin
            if ((k != 4'd0 || bf_state == 5'd13) && !stall) k <= k + 4'd1;
            if (bf_state == 5'd13 && k == 4'd2) begin
                ca_r <= bf_in_r;
                ca_i <= bf_in_i;
            end
            if (bf_state == 5'd15 && k == 4'd8) begin
                cb_r <= bf_in_r;
                cb_i <= bf_in_i;
            end
            if (k == 4'd5) begin
                cw_r <= twr(int'(tw_addr));
                cw_i <= twi(int'(tw_addr));
            end
        end
    end

    assign bf_k = k;

    longint pr, pi, o_r, o_i;
    always_comb begin
        pr = (cw_r * cb_r - cw_i * cb_i) / 127;
        pi = (cw_r * cb_i + cw_i * cb_r) / 127;
        o_r = 0;
        o_i = 0;
        if (bf_state == 5'd16) begin
            o_r = ca_r + pr;
            o_i = ca_i + pi;
        end else if (bf_state == 5'd17) begin
            o_r = ca_r - pr;
            o_i = ca_i - pi;
        end
        bf_out_r = o_r[DW-1:0];
        bf_out_i = o_i[DW-1:0];
    end

    // Reference FFT: expected reads, twiddles, operands and writes per pair
    int e_rd [2*NB];
    int e_tw [NB];
    longint e_oar [NB], e_oai [NB], e_obr [NB], e_obi [NB];
    longint e_wr [2*NB], e_wi [2*NB];
    longint fin_r [N], fin_i [N];

    task automatic build_model();
        longint mr [N];
        longint mi [N];
        longint xr, xi;
        int bi, half, a, b, t;
        bi = 0;
        for (int i = 0; i < N; i++) begin
            mr[i] = init_r[i];
            mi[i] = init_i[i];
        end
        for (int s = 0; s < LOGN; s++) begin
            half = 1 << s;
            for (int p = 0; p < N / 2; p++) begin
                a = ((p >> s) << (s + 1)) + (p & (half - 1));
                b = a + half;
                t = (p & (half - 1)) << (LOGN - 1 - s);
                e_rd[2*bi] = a;
                e_rd[2*bi+1] = b;
                e_tw[bi] = t;
                e_oar[bi] = mr[a]; e_oai[bi] = mi[a];
                e_obr[bi] = mr[b]; e_obi[bi] = mi[b];
                xr = (twr(t) * mr[b] - twi(t) * mi[b]) / 127;
                xi = (twr(t) * mi[b] + twi(t) * mr[b]) / 127;
                e_wr[2*bi] = mr[a] + xr;
                e_wi[2*bi] = mi[a] + xi;
                e_wr[2*bi+1] = mr[a] - xr;
                e_wi[2*bi+1] = mi[a] - xi;
                mr[a] = e_wr[2*bi];   mi[a] = e_wi[2*bi];
                mr[b] = e_wr[2*bi+1]; mi[b] = e_wi[2*bi+1];
                bi++;
            end
        end
        for (int i = 0; i < N; i++) begin
            fin_r[i] = mr[i];
            fin_i[i] = mi[i];
        end
    endtask

    task automatic load_ram();
        do_init = 1'b1;
        @(negedge clk);
        do_init = 1'b0;
    endtask

    task automatic reset_mid_run();
        stall = 1'b0;
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_bf_state", bf_state, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_bf_in", bf_in_r, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rst_hold_quiet", {mem_wr_en, mem_rd_en, busy}, 0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {mem_wr_en, mem_rd_en, busy}, 0);
        end
    endtask

    int obs_a [NB];
    int obs_tw [NB];

    // Start one FFT and check every cycle against the reference traffic
    task automatic run_fft(input bit stall_en, input bit poke, input int abort_at);
        int rd_i, wr_i, dones;
        bit fin;
        rd_i = 0;
        wr_i = 0;
        dones = 0;
        fin = 1'b0;
        build_model();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (cyc == abort_at) begin
                reset_mid_run();
                return;
            end
            if (mem_rd_en && mem_wr_en) chk("rd_wr_overlap", 1, 0);
            if (mem_rd_en) begin
                if (rd_i >= 2 * NB) begin
                    chk("extra_read", rd_i, 2 * NB - 1);
                end else begin
                    chk($sformatf("rd_addr[%0d]", rd_i), mem_addr, e_rd[rd_i]);
                    if (rd_i % 2 == 1) begin
                        obs_tw[rd_i/2] = int'(tw_addr);
                        chk("tw_addr", tw_addr, e_tw[rd_i/2]);
                        chk("bf_in_a_r", bf_in_r, e_oar[rd_i/2]);
                        chk("bf_in_a_i", bf_in_i, e_oai[rd_i/2]);
                    end else begin
                        obs_a[rd_i/2] = int'(mem_addr);
                    end
                end
                rd_i++;
            end
            if (mem_wr_en) begin
                if (wr_i >= 2 * NB) begin
                    chk("extra_write", wr_i, 2 * NB - 1);
                end else begin
                    chk($sformatf("wr_addr[%0d]", wr_i), mem_addr, e_rd[wr_i]);
                    chk($sformatf("wr_r[%0d]", wr_i), mem_wdata_r, e_wr[wr_i]);
                    chk($sformatf("wr_i[%0d]", wr_i), mem_wdata_i, e_wi[wr_i]);
                    chk("wr_phase_k", bf_k, (wr_i % 2 == 1) ? 0 : 9);
                    chk("wr_after_reads", rd_i, 2 * (wr_i / 2) + 2);
                    if (wr_i % 2 == 0) chk("bf_in_b_r", bf_in_r, e_obr[wr_i/2]);
                end
                wr_i++;
            end
            if (done) begin
                dones++;
                chk("busy_at_done", busy, 1);
                chk("writes_at_done", wr_i, 2 * NB);
            end else if (dones > 0) begin
                chk("busy_after_done", busy, 0);
                fin = 1'b1;
            end
            if (!fin) begin
                stall = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
                start = (poke && (cyc == 40 || cyc == 120)) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        stall = 1'b0;
        start = 1'b0;
        if (!fin) chk("run_timeout", 0, 1);
        chk("done_pulses", dones, 1);
        chk("reads_total", rd_i, 2 * NB);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ram_r[%0d]", i), ram_r[i], fin_r[i]);
            chk($sformatf("ram_i[%0d]", i), ram_i[i], fin_i[i]);
        end
    endtask

    int lit_a [NB] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_tw [NB] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    longint mix_r [N] = '{50, -20, 33, 7, -64, 12, 90, -5};
    longint mix_i [N] = '{-3, 40, 0, -17, 25, 8, -60, 11};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", mem_rd_en, 0);
        chk("reset_wr_en", mem_wr_en, 0);
        chk("reset_bf_state", bf_state, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_tw", tw_addr, 0);
        chk("reset_wdata", mem_wdata_r, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < N; i++) begin
            init_r[i] = 10;
            init_i[i] = 0;
        end
        load_ram();
        run_fft(1'b0, 1'b0, -1);
        chk("dc_bin0_r", ram_r[0], 80);
        chk("dc_bin0_i", ram_i[0], 0);
        for (int i = 1; i < N; i++) begin
            chk($sformatf("dc_bin%0d", i), {ram_r[i], ram_i[i]}, 0);
        end
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("trace_a[%0d]", i), obs_a[i], lit_a[i]);
            chk($sformatf("trace_tw[%0d]", i), obs_tw[i], lit_tw[i]);
        end

        for (int i = 0; i < N; i++) begin
            init_r[i] = 0;
            init_i[i] = 0;
        end
        init_r[0] = 100;
        load_ram();
        run_fft(1'b0, 1'b0, -1);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("imp_r[%0d]", i),
                (ram_r[i] >= 99 && ram_r[i] <= 101) ? 1 : 0, 1);
            chk($sformatf("imp_i[%0d]", i),
                (ram_i[i] >= -1 && ram_i[i] <= 1) ? 1 : 0, 1);
        end

        for (int i = 0; i < N; i++) begin
            init_r[i] = mix_r[i];
            init_i[i] = mix_i[i];
        end
        load_ram();
        run_fft(1'b1, 1'b1, -1);

        load_ram();
        run_fft(1'b1, 1'b0, 60);

        for (int i = 0; i < N; i++) begin
            init_r[i] = 10;
            init_i[i] = 0;
        end
        load_ram();
        run_fft(1'b0, 1'b0, -1);
        chk("recover_bin0", ram_r[0], 80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
